// File: rtl/lcd_cmd_arbiter.sv
// lcd_cmd_arbiter: shares one PMOD CLS command interface (clear / line1 /
// line2 strobes plus command_ready handshake) among parm_num_req requesters.
// One owner holds the grant at a time, a lock keeps it across a multi-command
// sequence, and a watchdog frees the interface if the driver hangs.
// Build option: define LCD_ARB_FIXED_PRIORITY_EN to arbitrate by lowest index
// instead of round-robin (default).
//
// Handshake: a requester raises a level request (clear/line1/line2) and keeps
// it until its o_ack pulse; the arbiter raises exactly one strobe while
// i_lcd_command_ready is high and drops it on the ce tick where ready is seen
// low (the driver has taken the command). The next command is only issued
// after ready returns high. All state changes happen on i_ce_2_5mhz ticks.
module lcd_cmd_arbiter #(
    parameter int parm_num_req       = 2,
    parameter int parm_timeout_ticks = 25000
) (
    input  logic                    i_clk_20mhz,
    input  logic                    i_rstn_20mhz,
    input  logic                    i_ce_2_5mhz,
    input  logic [parm_num_req-1:0] i_req_clear,
    input  logic [parm_num_req-1:0] i_req_line1,
    input  logic [parm_num_req-1:0] i_req_line2,
    input  logic [parm_num_req-1:0] i_lock,
    output logic [parm_num_req-1:0] o_grant,
    output logic [1:0]              o_grant_idx,
    output logic [parm_num_req-1:0] o_ack,
    output logic                    o_timeout,
    input  logic                    i_lcd_command_ready,
    output logic                    o_lcd_wr_clear_display,
    output logic                    o_lcd_wr_text_line1,
    output logic                    o_lcd_wr_text_line2,
    output logic [1:0]              o_dbg_state
);

    localparam int WD_W = $clog2(parm_timeout_ticks + 1);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(parm_timeout_ticks - 1);
    localparam logic [WD_W-1:0] WD_MAX  = WD_W'(parm_timeout_ticks);

    typedef enum logic [1:0] {
        ST_ARB   = 2'd0,
        ST_OWN   = 2'd1,
        ST_ISSUE = 2'd2,
        ST_WAIT  = 2'd3
    } state_t;

    state_t                  state_q, state_d;
    logic [parm_num_req-1:0] grant_q, grant_d;
    logic [1:0]              idx_q, idx_d;
    logic [parm_num_req-1:0] ack_q, ack_d;
    logic                    timeout_q, timeout_d;
    logic [2:0]              strb_q, strb_d;   // {clear, line1, line2}
    logic [WD_W-1:0]         wd_q, wd_d;

    logic [parm_num_req-1:0] req;
    logic [parm_num_req-1:0] cand;
    logic                    req_own, lock_own, clear_own, line1_own;
    logic                    win_found;
    logic [1:0]              win_idx;
    logic [parm_num_req-1:0] win_onehot;

    assign req       = i_req_clear | i_req_line1 | i_req_line2;
    assign cand      = req | i_lock;
    // grant_q is one-hot, so masking selects the owner's bits without an index
    assign req_own   = |(req & grant_q);
    assign lock_own  = |(i_lock & grant_q);
    assign clear_own = |(i_req_clear & grant_q);
    assign line1_own = |(i_req_line1 & grant_q);

`ifdef LCD_ARB_FIXED_PRIORITY_EN
    // Winner select: lowest-index candidate
    always_comb begin
        int win_int;
        win_found  = 1'b0;
        win_int    = 0;
        win_onehot = '0;
        for (int i = parm_num_req - 1; i >= 0; i--) begin
            if (cand[i]) begin
                win_found = 1'b1;
                win_int   = i;
            end
        end
        for (int i = 0; i < parm_num_req; i++) begin
            win_onehot[i] = win_found && (i == win_int);
        end
        win_idx = 2'(win_int);
    end
`else
    logic [1:0] ptr_q;

    // Winner select: first candidate after the round-robin pointer, wrapping
    always_comb begin
        int win_int;
        int c;
        win_found  = 1'b0;
        win_int    = 0;
        c          = 0;
        win_onehot = '0;
        for (int off = 1; off <= parm_num_req; off++) begin
            c = (int'(ptr_q) + off) % parm_num_req;
            if (!win_found && cand[c]) begin
                win_found = 1'b1;
                win_int   = c;
            end
        end
        for (int i = 0; i < parm_num_req; i++) begin
            win_onehot[i] = win_found && (i == win_int);
        end
        win_idx = 2'(win_int);
    end

    // Round-robin pointer: remembers the most recent winner
    always_ff @(posedge i_clk_20mhz or negedge i_rstn_20mhz) begin
        if (!i_rstn_20mhz) begin
            ptr_q <= 2'(parm_num_req - 1);
        end else if (i_ce_2_5mhz && (state_q == ST_ARB) && win_found) begin
            ptr_q <= win_idx;
        end
    end
`endif

    // Next-state, registered-output and watchdog computation
    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        idx_d     = idx_q;
        ack_d     = '0;
        timeout_d = 1'b0;
        strb_d    = strb_q;
        wd_d      = wd_q;

        case (state_q)
            ST_ARB: begin
                strb_d = 3'b000;
                if (win_found) begin
                    grant_d = win_onehot;
                    idx_d   = win_idx;
                    state_d = ST_OWN;
                end
            end
            ST_OWN: begin
                if (req_own && i_lcd_command_ready) begin
                    // clear > line1 > line2, frozen for the whole command
                    if (clear_own)      strb_d = 3'b100;
                    else if (line1_own) strb_d = 3'b010;
                    else                strb_d = 3'b001;
                    state_d = ST_ISSUE;
                end else if (!req_own && !lock_own) begin
                    grant_d = '0;
                    idx_d   = 2'd0;
                    state_d = ST_ARB;
                end
            end
            ST_ISSUE: begin
                if (!i_lcd_command_ready) begin
                    ack_d   = grant_q;
                    strb_d  = 3'b000;
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                strb_d = 3'b000;
                if (i_lcd_command_ready) state_d = ST_OWN;
            end
            default: begin
                strb_d  = 3'b000;
                grant_d = '0;
                idx_d   = 2'd0;
                state_d = ST_ARB;
            end
        endcase

        // Watchdog expiry overrides whatever the handshake would have done
        if (((state_q == ST_ISSUE) || (state_q == ST_WAIT)) && (wd_q == WD_LAST)) begin
            timeout_d = 1'b1;
            ack_d     = '0;
            strb_d    = 3'b000;
            grant_d   = '0;
            idx_d     = 2'd0;
            state_d   = ST_ARB;
        end

        if (state_d != state_q) begin
            wd_d = '0;
        end else if (((state_q == ST_ISSUE) || (state_q == ST_WAIT)) && (wd_q != WD_MAX)) begin
            wd_d = wd_q + WD_W'(1);
        end
    end

    // State and output registers, advanced on clock-enable ticks only
    always_ff @(posedge i_clk_20mhz or negedge i_rstn_20mhz) begin
        if (!i_rstn_20mhz) begin
            state_q   <= ST_ARB;
            grant_q   <= '0;
            idx_q     <= 2'd0;
            ack_q     <= '0;
            timeout_q <= 1'b0;
            strb_q    <= 3'b000;
            wd_q      <= '0;
        end else if (i_ce_2_5mhz) begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            idx_q     <= idx_d;
            ack_q     <= ack_d;
            timeout_q <= timeout_d;
            strb_q    <= strb_d;
            wd_q      <= wd_d;
        end
    end

    assign o_grant                = grant_q;
    assign o_grant_idx            = idx_q;
    assign o_ack                  = ack_q;
    assign o_timeout              = timeout_q;
    assign o_lcd_wr_clear_display = strb_q[2];
    assign o_lcd_wr_text_line1    = strb_q[1];
    assign o_lcd_wr_text_line2    = strb_q[0];
    assign o_dbg_state            = state_q;

endmodule

// File: tb/tb_lcd_cmd_arbiter.sv
// Testbench for lcd_cmd_arbiter (2 requesters, short watchdog).
// Observed word per comparison: {grant[1:0], idx[1:0], ack[1:0], timeout,
// strobes {clear,line1,line2}, state[1:0]}; state 0=ARB 1=OWN 2=ISSUE 3=WAIT.
module tb_lcd_cmd_arbiter;

    localparam int N  = 2;
    localparam int TO = 20;

    logic         clk = 1'b0;
    logic         rstn = 1'b0;
    logic         ce = 1'b0;
    logic [N-1:0] clr = '0, l1 = '0, l2 = '0, lock = '0;
    logic         rdy = 1'b1;
    logic [N-1:0] grant, ack;
    logic [1:0]   idx, st;
    logic         tmo, s_clr, s_l1, s_l2;

    int cmp_n = 0;
    int err_n = 0;

    lcd_cmd_arbiter #(.parm_num_req(N), .parm_timeout_ticks(TO)) dut (
        .i_clk_20mhz            (clk),
        .i_rstn_20mhz           (rstn),
        .i_ce_2_5mhz            (ce),
        .i_req_clear            (clr),
        .i_req_line1            (l1),
        .i_req_line2            (l2),
        .i_lock                 (lock),
        .o_grant                (grant),
        .o_grant_idx            (idx),
        .o_ack                  (ack),
        .o_timeout              (tmo),
        .i_lcd_command_ready    (rdy),
        .o_lcd_wr_clear_display (s_clr),
        .o_lcd_wr_text_line1    (s_l1),
        .o_lcd_wr_text_line2    (s_l2),
        .o_dbg_state            (st)
    );

    // Clock and reset: 20 MHz clock; reset is driven from the stimulus block
    always #25 clk = ~clk;

    initial begin
        #2ms;
        $display("FAIL global_time_limit: actual expired required finish");
        $fatal(1, "time limit");
    end

    typedef struct {
        logic [1:0] clr, l1, l2, lock;
        logic       rdy;
        logic [1:0] grant, idx, ack;
        logic       to;
        logic [2:0] strb;
        logic [1:0] st;
    } vec_t;

    vec_t vecs[16];

    function automatic vec_t mk(input logic [1:0] c, input logic [1:0] a, input logic [1:0] b,
                                input logic [1:0] lk, input logic r, input logic [1:0] g,
                                input logic [1:0] ix, input logic [1:0] ak, input logic t,
                                input logic [2:0] s, input logic [1:0] q);
        vec_t v;
        v.clr = c; v.l1 = a; v.l2 = b; v.lock = lk; v.rdy = r;
        v.grant = g; v.idx = ix; v.ack = ak; v.to = t; v.strb = s; v.st = q;
        return v;
    endfunction

    function automatic logic [11:0] pack(input logic [1:0] g, input logic [1:0] ix,
                                         input logic [1:0] ak, input logic t,
                                         input logic [2:0] s, input logic [1:0] q);
        return {g, ix, ak, t, s, q};
    endfunction

    function automatic logic [11:0] observed();
        return {grant, idx, ack, tmo, s_clr, s_l1, s_l2, st};
    endfunction

    // Scoreboard compare: one line per failure
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        cmp_n++;
        if (act !== exp) begin
            err_n++;
            $display("FAIL %s: actual %0h required %0h", name, act, exp);
        end
    endtask

    // Driver: one ce tick, followed by idle clocks so gating is exercised;
    // returns at a falling edge, away from the active edge
    task automatic tick();
        @(negedge clk); ce = 1'b1;
        @(negedge clk); ce = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk); rstn = 1'b0;
        repeat (3) @(negedge clk);
        rstn = 1'b1;
    endtask

    // Locked owner 0 issues one command: strobe, ack, back to OWN with grant kept
    task automatic locked_cmd(input int cmd);
        logic [2:0] s;
        s = 3'b100 >> cmd;
        clr[0] = (cmd == 0); l1[0] = (cmd == 1); l2[0] = (cmd == 2);
        rdy = 1'b1;
        tick();
        chk($sformatf("lock_cmd%0d_strobe", cmd), observed(), pack(2'b01, 2'd0, 2'b00, 1'b0, s, 2'd2));
        rdy = 1'b0;
        tick();
        chk($sformatf("lock_cmd%0d_ack", cmd), observed(), pack(2'b01, 2'd0, 2'b01, 1'b0, 3'b000, 2'd3));
        clr[0] = 1'b0; l1[0] = 1'b0; l2[0] = 1'b0;
        rdy = 1'b1;
        tick();
        chk($sformatf("lock_cmd%0d_held", cmd), observed(), pack(2'b01, 2'd0, 2'b00, 1'b0, 3'b000, 2'd1));
    endtask

    initial begin
        int order[4];
        int exp_order[4];
        int drop[N];
        int served;

        // Test 1 (single line1 request) and test 5 (clear before line2)
        vecs[0]  = mk(2'b00, 2'b01, 2'b00, 2'b00, 1'b1, 2'b01, 2'd0, 2'b00, 1'b0, 3'b000, 2'd1);
        vecs[1]  = mk(2'b00, 2'b01, 2'b00, 2'b00, 1'b1, 2'b01, 2'd0, 2'b00, 1'b0, 3'b010, 2'd2);
        vecs[2]  = mk(2'b00, 2'b01, 2'b00, 2'b00, 1'b1, 2'b01, 2'd0, 2'b00, 1'b0, 3'b010, 2'd2);
        vecs[3]  = mk(2'b00, 2'b00, 2'b00, 2'b00, 1'b1, 2'b01, 2'd0, 2'b00, 1'b0, 3'b010, 2'd2);
        vecs[4]  = mk(2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 2'b01, 2'd0, 2'b01, 1'b0, 3'b000, 2'd3);
        vecs[5]  = mk(2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 2'b01, 2'd0, 2'b00, 1'b0, 3'b000, 2'd3);
        vecs[6]  = mk(2'b00, 2'b00, 2'b00, 2'b00, 1'b1, 2'b01, 2'd0, 2'b00, 1'b0, 3'b000, 2'd1);
        vecs[7]  = mk(2'b00, 2'b00, 2'b00, 2'b00, 1'b1, 2'b00, 2'd0, 2'b00, 1'b0, 3'b000, 2'd0);
        vecs[8]  = mk(2'b10, 2'b00, 2'b10, 2'b00, 1'b1, 2'b10, 2'd1, 2'b00, 1'b0, 3'b000, 2'd1);
        vecs[9]  = mk(2'b10, 2'b00, 2'b10, 2'b00, 1'b1, 2'b10, 2'd1, 2'b00, 1'b0, 3'b100, 2'd2);
        vecs[10] = mk(2'b10, 2'b00, 2'b10, 2'b00, 1'b0, 2'b10, 2'd1, 2'b10, 1'b0, 3'b000, 2'd3);
        vecs[11] = mk(2'b00, 2'b00, 2'b10, 2'b00, 1'b1, 2'b10, 2'd1, 2'b00, 1'b0, 3'b000, 2'd1);
        vecs[12] = mk(2'b00, 2'b00, 2'b10, 2'b00, 1'b1, 2'b10, 2'd1, 2'b00, 1'b0, 3'b001, 2'd2);
        vecs[13] = mk(2'b00, 2'b00, 2'b10, 2'b00, 1'b0, 2'b10, 2'd1, 2'b10, 1'b0, 3'b000, 2'd3);
        vecs[14] = mk(2'b00, 2'b00, 2'b00, 2'b00, 1'b1, 2'b10, 2'd1, 2'b00, 1'b0, 3'b000, 2'd1);
        vecs[15] = mk(2'b00, 2'b00, 2'b00, 2'b00, 1'b1, 2'b00, 2'd0, 2'b00, 1'b0, 3'b000, 2'd0);

        repeat (3) @(negedge clk);
        chk("reset_state", observed(), pack(2'b00, 2'd0, 2'b00, 1'b0, 3'b000, 2'd0));
        @(negedge clk); rstn = 1'b1;

        for (int i = 0; i < 16; i++) begin
            clr = vecs[i].clr; l1 = vecs[i].l1; l2 = vecs[i].l2;
            lock = vecs[i].lock; rdy = vecs[i].rdy;
            tick();
            chk($sformatf("vec%0d", i), observed(),
                pack(vecs[i].grant, vecs[i].idx, vecs[i].ack, vecs[i].to, vecs[i].strb, vecs[i].st));
        end

        // Test 3: lock[0] holds the grant across three commands while req1 waits
        lock = 2'b01; clr = 2'b10; rdy = 1'b1;
        tick();
        chk("lock_grant0", observed(), pack(2'b01, 2'd0, 2'b00, 1'b0, 3'b000, 2'd1));
        for (int c = 0; c < 3; c++) locked_cmd(c);
        tick();
        chk("lock_idle_hold", observed(), pack(2'b01, 2'd0, 2'b00, 1'b0, 3'b000, 2'd1));
        lock = 2'b00;
        tick();
        chk("unlock_release", observed(), pack(2'b00, 2'd0, 2'b00, 1'b0, 3'b000, 2'd0));
        tick();
        chk("unlock_grant1", observed(), pack(2'b10, 2'd1, 2'b00, 1'b0, 3'b000, 2'd1));

        // Test 4: ready never drops, watchdog expires TO ticks after the strobe
        l1 = 2'b01;
        tick();
        chk("wd_strobe", observed(), pack(2'b10, 2'd1, 2'b00, 1'b0, 3'b100, 2'd2));
        for (int k = 1; k < TO; k++) begin
            tick();
            chk($sformatf("wd_run%0d", k), observed(), pack(2'b10, 2'd1, 2'b00, 1'b0, 3'b100, 2'd2));
        end
        tick();
        chk("wd_expire", observed(), pack(2'b00, 2'd0, 2'b00, 1'b1, 3'b000, 2'd0));
        tick();
        chk("wd_next_owner", observed(), pack(2'b01, 2'd0, 2'b00, 1'b0, 3'b000, 2'd1));

        // Test 6: asynchronous reset in the middle of ST_ISSUE
        tick();
        chk("rst_pre_issue", observed(), pack(2'b01, 2'd0, 2'b00, 1'b0, 3'b010, 2'd2));
        @(posedge clk); #5; rstn = 1'b0; #1;
        chk("rst_async_clear", observed(), pack(2'b00, 2'd0, 2'b00, 1'b0, 3'b000, 2'd0));
        @(negedge clk); rstn = 1'b1;
        tick();
        chk("rst_req0_first", observed(), pack(2'b01, 2'd0, 2'b00, 1'b0, 3'b000, 2'd1));

        // Test 2: two requesters both asking for clear, each drops after its ack
        do_reset();
        clr = 2'b11; l1 = 2'b00; l2 = 2'b00; lock = 2'b00; rdy = 1'b1;
        drop[0] = 0; drop[1] = 0;
        served = 0;
`ifdef LCD_ARB_FIXED_PRIORITY_EN
        exp_order = '{0, 0, 0, 0};
`else
        exp_order = '{0, 1, 0, 1};
`endif
        for (int t = 0; t < 200 && served < 4; t++) begin
            tick();
            for (int k = 0; k < N; k++) if (drop[k] > 0) drop[k]--;
            if (ack != 2'b00) begin
                order[served] = ack[1] ? 1 : 0;
                drop[order[served]] = 2;
                served++;
            end
            rdy = !(s_clr | s_l1 | s_l2);
            for (int k = 0; k < N; k++) clr[k] = (drop[k] == 0);
        end
        chk("rr_services_done", 32'(served), 32'd4);
        for (int i = 0; i < 4; i++) begin
            if (i < served) chk($sformatf("rr_order%0d", i), 32'(order[i]), 32'(exp_order[i]));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_n, err_n);
        $finish;
    end

endmodule
